// File: rtl/id_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : id_inst_queue
// Description : Instruction queue and issue interlock between the Icache and
//               the ID decoder. Buffers {pc, inst} pairs in a DEPTH-entry FIFO,
//               discards in-flight fetches after a flush, and holds the head
//               back while it reads a register still being loaded.
//
// Ports       : clk, rst_n                 clock, async active-low reset
//               Icache_inst_i/_pc_i        fetched instruction and its PC
//               fc_Icache_data_valid_i     push strobe
//               fc_flush_id_i              flush queue/scoreboard/in-flight
//               fc_bk_id_i                 freeze ID (no issue, scoreboard holds)
//               iq_ready_o                 queue not full (registered)
//               iq_inst_o / iq_pc_o        head to ID, zero when not issuing
//               iq_valid_o                 issue this cycle
//               iq_load_use_flag_o         head blocked by load-use hazard
//               iq_count_o                 occupancy
//               iq_overflow_o              sticky push-while-full indicator
//
// Revision    : 1.0  initial release
// ============================================================================
module id_inst_queue #(
  parameter int DEPTH      = 4,
  parameter int LU_WINDOW  = 1,
  parameter int FLUSH_DROP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              Icache_inst_i,
  input  logic [31:0]              Icache_pc_i,
  input  logic                     fc_Icache_data_valid_i,
  input  logic                     fc_flush_id_i,
  input  logic                     fc_bk_id_i,
  output logic                     iq_ready_o,
  output logic [31:0]              iq_inst_o,
  output logic [31:0]              iq_pc_o,
  output logic                     iq_valid_o,
  output logic                     iq_load_use_flag_o,
  output logic [$clog2(DEPTH):0]   iq_count_o,
  output logic                     iq_overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] c_depth      = CW'(DEPTH);
  localparam logic [1:0]    c_flush_drop = 2'(FLUSH_DROP);

  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_stype = 7'b0100011;
  localparam logic [6:0] c_op_btype = 7'b1100011;
  localparam logic [6:0] c_op_load  = 7'b0000011;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]          r_mem_inst [DEPTH];
  logic [31:0]          r_mem_pc   [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [1:0]           r_drop;
  logic [LU_WINDOW-1:0] r_sb_v;
  logic [4:0]           r_sb_rd [LU_WINDOW];
  logic                 r_overflow;
  logic                 r_ready;

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  logic        w_empty;
  logic        w_full;
  logic [31:0] w_head_inst;
  logic [31:0] w_head_pc;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  assign w_head_inst = r_mem_inst[r_rd_ptr];
  assign w_head_pc   = r_mem_pc[r_rd_ptr];
  assign w_opcode    = w_head_inst[6:0];
  assign w_rd        = w_head_inst[11:7];
  assign w_rs1       = w_head_inst[19:15];
  assign w_rs2       = w_head_inst[24:20];

  // An all-zero word is treated as a bubble and reads nothing.
  assign w_use_rs1 = (w_head_inst != 32'h0) &&
                     (w_opcode != c_op_lui) &&
                     (w_opcode != c_op_auipc) &&
                     (w_opcode != c_op_jal);
  assign w_use_rs2 = (w_head_inst != 32'h0) &&
                     ((w_opcode == c_op_rtype) ||
                      (w_opcode == c_op_stype) ||
                      (w_opcode == c_op_btype));

  // --------------------------------------------------------------------------
  // Load-use detection against every valid scoreboard slot
  // --------------------------------------------------------------------------
  logic w_load_use;

  always_comb begin
    w_load_use = 1'b0;
    for (int i = 0; i < LU_WINDOW; i++) begin
      if (r_sb_v[i]) begin
        if (w_use_rs1 && (w_rs1 != 5'd0) && (w_rs1 == r_sb_rd[i]))
          w_load_use = 1'b1;
        if (w_use_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_sb_rd[i]))
          w_load_use = 1'b1;
      end
    end
    w_load_use = w_load_use && !w_empty;
  end

  // --------------------------------------------------------------------------
  // Push / issue control
  // --------------------------------------------------------------------------
  logic          w_issue;
  logic          w_push;
  logic          w_drop_dec;
  logic          w_overflow_set;
  logic          w_sb_in_v;
  logic [CW-1:0] w_count_nxt;

  assign w_issue        = !w_empty && !fc_bk_id_i && !fc_flush_id_i && !w_load_use;
  assign w_push         = fc_Icache_data_valid_i && !w_full && (r_drop == 2'd0) &&
                          !fc_flush_id_i;
  // Responses still in flight from before a flush are swallowed here.
  assign w_drop_dec     = fc_Icache_data_valid_i && (r_drop != 2'd0) && !fc_flush_id_i;
  assign w_overflow_set = fc_Icache_data_valid_i && w_full && !fc_flush_id_i;
  assign w_sb_in_v      = w_issue && (w_opcode == c_op_load) && (w_rd != 5'd0);

  always_comb begin
    if (fc_flush_id_i)
      w_count_nxt = '0;
    else
      w_count_nxt = r_count + CW'(w_push) - CW'(w_issue);
  end

  // --------------------------------------------------------------------------
  // Storage (no reset needed: contents are only read below the count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= Icache_inst_i;
      r_mem_pc[r_wr_ptr]   <= Icache_pc_i;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, drop counter, flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop     <= 2'd0;
      r_overflow <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < c_depth);
      if (w_overflow_set)
        r_overflow <= 1'b1;
      if (fc_flush_id_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_drop   <= c_flush_drop;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_issue)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_drop_dec)
          r_drop <= r_drop - 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load scoreboard: a shift register advanced every unfrozen cycle, so a
  // blocked head sees bubbles shift in and the hazard self-clears.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_v <= '0;
      for (int i = 0; i < LU_WINDOW; i++)
        r_sb_rd[i] <= 5'd0;
    end else if (fc_flush_id_i) begin
      r_sb_v <= '0;
      for (int i = 0; i < LU_WINDOW; i++)
        r_sb_rd[i] <= 5'd0;
    end else if (!fc_bk_id_i) begin
      r_sb_v[0]  <= w_sb_in_v;
      r_sb_rd[0] <= w_rd;
      for (int i = 1; i < LU_WINDOW; i++) begin
        r_sb_v[i]  <= r_sb_v[i-1];
        r_sb_rd[i] <= r_sb_rd[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign iq_valid_o         = w_issue;
  assign iq_inst_o          = w_issue ? w_head_inst : 32'h0;
  assign iq_pc_o            = w_issue ? w_head_pc   : 32'h0;
  assign iq_load_use_flag_o = w_load_use && !fc_bk_id_i && !fc_flush_id_i;
  assign iq_count_o         = r_count;
  assign iq_ready_o         = r_ready;
  assign iq_overflow_o      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_id_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_inst_queue
// Description : Directed self-checking bench for id_inst_queue. Two instances
//               share stimulus: dut_a with LU_WINDOW=1, dut_b with LU_WINDOW=2.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_inst_queue;

  localparam logic [31:0] c_nop   = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] c_lw    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] c_add   = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] c_lw_x0 = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] c_addx0 = 32'h0020_0333; // add  x6,x0,x2
  localparam logic [31:0] c_sw    = 32'h0020_A2A3; // sw   x2,5(x1)  (imm[4:0]=5)
  localparam logic [31:0] c_lui   = 32'h0002_82B7; // lui  x5,0x28   (bits19:15=5)

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        flush_i;
  logic        bk_i;

  logic        ready_a, valid_a, flag_a, ovf_a;
  logic [31:0] inst_a, pc_a;
  logic [2:0]  cnt_a;
  logic        ready_b, valid_b, flag_b, ovf_b;
  logic [31:0] inst_b, pc_b;
  logic [2:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_inst_queue #(.DEPTH(4), .LU_WINDOW(1), .FLUSH_DROP(1)) dut_a (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .Icache_inst_i          (inst_i),
    .Icache_pc_i            (pc_i),
    .fc_Icache_data_valid_i (valid_i),
    .fc_flush_id_i          (flush_i),
    .fc_bk_id_i             (bk_i),
    .iq_ready_o             (ready_a),
    .iq_inst_o              (inst_a),
    .iq_pc_o                (pc_a),
    .iq_valid_o             (valid_a),
    .iq_load_use_flag_o     (flag_a),
    .iq_count_o             (cnt_a),
    .iq_overflow_o          (ovf_a)
  );

  id_inst_queue #(.DEPTH(4), .LU_WINDOW(2), .FLUSH_DROP(1)) dut_b (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .Icache_inst_i          (inst_i),
    .Icache_pc_i            (pc_i),
    .fc_Icache_data_valid_i (valid_i),
    .fc_flush_id_i          (flush_i),
    .fc_bk_id_i             (bk_i),
    .iq_ready_o             (ready_b),
    .iq_inst_o              (inst_b),
    .iq_pc_o                (pc_b),
    .iq_valid_o             (valid_b),
    .iq_load_use_flag_o     (flag_b),
    .iq_count_o             (cnt_b),
    .iq_overflow_o          (ovf_b)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic f, input logic b);
    valid_i = v;
    inst_i  = ins;
    pc_i    = p;
    flush_i = f;
    bk_i    = b;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Two back-to-back pushes where the second must issue right after the first.
  task automatic no_stall_pair(input string tag, input logic [31:0] first,
                               input logic [31:0] second, input logic [31:0] p);
    drive(1'b1, first, p, 1'b0, 1'b0);
    tick();
    drive(1'b1, second, p + 32'd4, 1'b0, 1'b0);
    chk1 ({tag, "_first_v"}, valid_a, 1'b1);
    chk32({tag, "_first_pc"}, pc_a, p);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1 ({tag, "_second_v_a"}, valid_a, 1'b1);
    chk32({tag, "_second_inst_a"}, inst_a, second);
    chk1 ({tag, "_second_flag_a"}, flag_a, 1'b0);
    chk1 ({tag, "_second_v_b"}, valid_b, 1'b1);
    chk32({tag, "_second_inst_b"}, inst_b, second);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // ---------------- reset values ----------------
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk1 ("rst_ready", ready_a, 1'b1);
    chk32("rst_count", 32'(cnt_a), 32'd0);
    chk1 ("rst_valid", valid_a, 1'b0);
    chk32("rst_inst",  inst_a, 32'h0);
    chk32("rst_pc",    pc_a, 32'h0);
    chk1 ("rst_flag",  flag_a, 1'b0);
    chk1 ("rst_ovf",   ovf_a, 1'b0);
    chk32("rst_count_b", 32'(cnt_b), 32'd0);
    rst_n = 1'b1;

    // ---------------- streaming, no stall ----------------
    drive(1'b1, c_nop, 32'h0, 1'b0, 1'b0);
    chk1("t1_no_bypass_v", valid_a, 1'b0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, c_nop, 32'(i * 4), 1'b0, 1'b0);
      chk1 ("t1_v",     valid_a, 1'b1);
      chk32("t1_pc",    pc_a, 32'((i - 1) * 4));
      chk32("t1_count", 32'(cnt_a), 32'd1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1 ("t1_last_v",  valid_a, 1'b1);
    chk32("t1_last_pc", pc_a, 32'hC);
    tick();
    chk32("t1_drain_count", 32'(cnt_a), 32'd0);
    chk1 ("t1_drain_v",     valid_a, 1'b0);

    // ---------------- fill while frozen, overflow ----------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, c_nop, 32'(i * 4), 1'b0, 1'b1);
      chk32("t2_count", 32'(cnt_a), 32'(i < 4 ? i : 4));
      chk1 ("t2_v",     valid_a, 1'b0);
      chk1 ("t2_ovf_pre", ovf_a, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk32("t2_full_count", 32'(cnt_a), 32'd4);
    chk1 ("t2_full_ready", ready_a, 1'b0);
    chk1 ("t2_ovf",        ovf_a, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk1 ("t2_rel_v",  valid_a, 1'b1);
      chk32("t2_rel_pc", pc_a, 32'(i * 4));
      tick();
    end
    chk32("t2_after_count", 32'(cnt_a), 32'd0);
    chk1 ("t2_after_ready", ready_a, 1'b1);
    chk1 ("t2_after_ovf",   ovf_a, 1'b1);
    // flush leaves the sticky overflow alone
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("t2_flush_ovf", ovf_a, 1'b1);
    // asynchronous reset takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    chk1 ("t2_async_ovf_a", ovf_a, 1'b0);
    chk1 ("t2_async_ovf_b", ovf_b, 1'b0);
    chk1 ("t2_async_ready", ready_a, 1'b1);
    tick();
    rst_n = 1'b1;

    // ---------------- load-use hazard ----------------
    drive(1'b1, c_lw, 32'h100, 1'b0, 1'b0);
    tick();
    drive(1'b1, c_add, 32'h104, 1'b0, 1'b0);
    chk32("t3_lw_inst_a", inst_a, c_lw);
    chk1 ("t3_lw_v_b",    valid_b, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1("t3_c0_v_a",    valid_a, 1'b0);
    chk1("t3_c0_flag_a", flag_a, 1'b1);
    chk32("t3_c0_inst_a", inst_a, 32'h0);
    chk1("t3_c0_v_b",    valid_b, 1'b0);
    chk1("t3_c0_flag_b", flag_b, 1'b1);
    tick();
    chk1 ("t3_c1_v_a",    valid_a, 1'b1);
    chk32("t3_c1_inst_a", inst_a, c_add);
    chk32("t3_c1_pc_a",   pc_a, 32'h104);
    chk1 ("t3_c1_flag_a", flag_a, 1'b0);
    chk1 ("t3_c1_v_b",    valid_b, 1'b0);
    chk1 ("t3_c1_flag_b", flag_b, 1'b1);
    tick();
    chk32("t3_c2_count_a", 32'(cnt_a), 32'd0);
    chk1 ("t3_c2_v_b",     valid_b, 1'b1);
    chk32("t3_c2_inst_b",  inst_b, c_add);
    chk1 ("t3_c2_flag_b",  flag_b, 1'b0);
    tick();
    chk32("t3_c3_count_b", 32'(cnt_b), 32'd0);

    // ---------------- no false hazards ----------------
    no_stall_pair("t4_lwx0", c_lw_x0, c_addx0, 32'h500);
    no_stall_pair("t4_sw",   c_sw,    c_add,   32'h600);
    no_stall_pair("t4_lui",  c_lw,    c_lui,   32'h700);

    // ---------------- flush with queued entries ----------------
    do_reset();
    drive(1'b1, c_lw, 32'h1F0, 1'b0, 1'b0);
    tick();
    drive(1'b1, c_nop, 32'h200, 1'b0, 1'b0);
    chk32("t5_lw_issue", inst_a, c_lw);
    tick();
    drive(1'b1, c_nop, 32'h204, 1'b0, 1'b1);
    chk32("t5_count1", 32'(cnt_a), 32'd1);
    tick();
    drive(1'b1, c_nop, 32'h208, 1'b0, 1'b1);
    chk32("t5_count2", 32'(cnt_a), 32'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk32("t5_count3", 32'(cnt_a), 32'd3);
    chk1 ("t5_flush_v", valid_a, 1'b0);
    tick();
    drive(1'b1, c_add, 32'h300, 1'b0, 1'b1);
    chk32("t5_post_count", 32'(cnt_a), 32'd0);
    chk1 ("t5_post_ready", ready_a, 1'b1);
    tick();
    drive(1'b1, c_add, 32'h304, 1'b0, 1'b1);
    chk32("t5_dropped_count", 32'(cnt_a), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk32("t5_queued_count", 32'(cnt_a), 32'd1);
    chk1 ("t5_issue_v_a",    valid_a, 1'b1);
    chk32("t5_issue_pc_a",   pc_a, 32'h304);
    chk1 ("t5_issue_flag_a", flag_a, 1'b0);
    chk1 ("t5_issue_v_b",    valid_b, 1'b1);
    chk32("t5_issue_pc_b",   pc_b, 32'h304);
    tick();
    chk32("t5_end_count", 32'(cnt_a), 32'd0);

    // ---------------- flush while frozen, push in flush cycle ----------------
    drive(1'b1, c_nop, 32'h400, 1'b0, 1'b1);
    tick();
    drive(1'b1, c_nop, 32'h404, 1'b0, 1'b1);
    chk32("t6_count1", 32'(cnt_a), 32'd1);
    tick();
    drive(1'b1, c_nop, 32'h408, 1'b1, 1'b1);
    chk32("t6_count2", 32'(cnt_a), 32'd2);
    tick();
    drive(1'b1, c_nop, 32'h40C, 1'b0, 1'b0);
    chk32("t6_flushed_count", 32'(cnt_a), 32'd0);
    chk1 ("t6_flushed_v",     valid_a, 1'b0);
    tick();
    drive(1'b1, c_nop, 32'h410, 1'b0, 1'b0);
    chk32("t6_drop_count", 32'(cnt_a), 32'd0);
    chk1 ("t6_drop_v",     valid_a, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk1 ("t6_issue_v",  valid_a, 1'b1);
    chk32("t6_issue_pc", pc_a, 32'h410);
    tick();
    chk32("t6_end_count", 32'(cnt_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction queue and issue interlock between Icache and the ID decoder.
- Generalises the single-entry ID instruction buffer into a DEPTH-entry FIFO of {pc, inst}.
- Adds a configurable post-flush drop count and an LU_WINDOW-deep load-use scoreboard.
- Emits one instruction per cycle to ID, or a 32'h0 bubble when stalled, flushed or empty.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- LU_WINDOW, 1: number of issued slots tracked for load-use hazards; range 1..4.
- FLUSH_DROP, 1: Icache valid responses discarded after a flush (in-flight fetches); range 0..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Icache_inst_i  in  32  fetched instruction
- Icache_pc_i  in  32  PC of fetched instruction
- fc_Icache_data_valid_i  in  1  push strobe
- fc_flush_id_i  in  1  flush queue, scoreboard and in-flight fetches
- fc_bk_id_i  in  1  freeze ID (Dcache stall); no issue, scoreboard holds
- iq_ready_o  out  1  queue not full
- iq_inst_o  out  32  instruction to ID; 32'h0 when iq_valid_o=0
- iq_pc_o  out  32  PC to ID; 32'h0 when iq_valid_o=0
- iq_valid_o  out  1  issue this cycle
- iq_load_use_flag_o  out  1  head blocked by load-use hazard
- iq_count_o  out  $clog2(DEPTH)+1  occupancy
- iq_overflow_o  out  1  sticky: push attempted while full

Behaviour:
- Reset: FIFO empty, pointers 0, drop counter 0, scoreboard cleared, overflow 0.
- Reset values: iq_ready_o=1, iq_count_o=0, all other outputs 0. Asynchronous reset mid-operation aborts everything.
- Push:
  - Occurs when valid_i=1, not full, drop counter 0 and no flush in the same cycle.
  - Entry becomes head-visible the next cycle; no write-to-issue bypass (latency 1).
  - Valid while full: data discarded, iq_overflow_o set until reset. Simultaneous pop does not make room in that cycle.
  - Valid while drop counter>0: data discarded, counter decremented.
- Issue (pop):
  - iq_valid_o = !empty && !fc_bk_id_i && !fc_flush_id_i && !load_use.
  - When issuing, iq_inst_o and iq_pc_o are the head entry (combinational from registers).
  - Push and pop in the same cycle: count unchanged.
- Source usage decode (head opcode):
  - rs1 is read unless the opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is read only for Rtype 0110011, Stype 0100011 and Btype 1100011.
  - An all-zero instruction reads neither.
- Scoreboard:
  - LU_WINDOW slots of {v, rd}. Each cycle with fc_bk_id_i=0, shift in {1, rd} if the issued instruction is a load (opcode 0000011) with rd!=0; otherwise shift in {0, -}. The oldest slot falls out.
  - Stores do not occupy the scoreboard.
  - While fc_bk_id_i=1 the scoreboard holds.
- load_use:
  - Asserted when the head is valid and a used rs1/rs2 (non-zero) equals rd of any valid slot.
  - Blocks issue; the bubble shifts in, so a hazard clears after at most LU_WINDOW cycles.
  - iq_load_use_flag_o = load_use && !fc_bk_id_i && !fc_flush_id_i.
- Flush:
  - Highest priority. Next cycle: FIFO empty, scoreboard cleared, drop counter = FLUSH_DROP.
  - Valid_i in the flush cycle is discarded and does not decrement the counter.
  - Flush during fc_bk_id_i=1 still flushes.
  - Flush does not clear iq_overflow_o.
- Priority: reset > flush > bk > load_use > issue.
- Pointers wrap modulo DEPTH; full = count==DEPTH.
- iq_ready_o = count<DEPTH, registered from state.

Test Plan:
- Push 4 instructions, no stall (DEPTH=4): pc 0x0..0xC. Each issues 1 cycle after push in order; iq_count_o peaks at 1.
- Hold fc_bk_id_i=1 and push 5 entries: count reaches 4, iq_ready_o=0, 5th dropped, iq_overflow_o=1. After release, pc 0x0..0xC issue on 4 consecutive cycles.
- Load-use hazard: issue lw x5,0(x1) (0x0000A283), then head add x6,x5,x2 (0x00228333). With LU_WINDOW=1: one bubble, iq_load_use_flag_o=1 for 1 cycle, add issues next. With LU_WINDOW=2: 2 bubbles.
- No false hazards:
  - lw x0 followed by add x6,x0,x2: no stall.
  - sw followed by a dependent add: no stall.
  - lui x5 after lw x5: no stall (no rs1 read).
- Flush with 3 entries queued, FLUSH_DROP=1: cycle after, count=0, iq_valid_o=0. The next valid push is dropped, the following one is queued and issues; a scoreboarded load is forgotten.
- Flush asserted while fc_bk_id_i=1 with valid_i=1 in the same cycle: push discarded, queue empty next cycle, drop counter=FLUSH_DROP.
